norflash16_arb: RTL and testbench

//  Two-master Wishbone arbiter placed in front of the norflash16 read-only flash slave.

---
 rtl/norflash16_arb.sv | 149 ++++++++++++++
 tb/tb_norflash16_arb.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norflash16_arb.sv
// norflash16_arb: two-master Wishbone arbiter in front of the norflash16 read-only slave.
// Master 0 is the CPU bus and master 1 is the DMA/boot bus. A grant is held for the
// whole cyc, then the arbiter re-arbitrates round-robin.
// Ports: sys_clk/sys_rst_n (async, active-low); m0_*/m1_* master ports
// (adr, cyc, stb, sel in; dat, ack out); s_* slave port; gnt_o one-hot {m1,m0};
// hold_err_o pulses once when a grant has been held HOLD_MAX cycles.
// Define NORFLASH16_ARB_PRIO_EN for fixed priority (m0 wins ties) instead of round-robin.
module norflash16_arb #(
  parameter int ADR_W    = 32,
  parameter int HOLD_MAX = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic [3:0]       m0_sel_i,
  output logic [31:0]      m0_dat_o,
  output logic             m0_ack_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic [3:0]       m1_sel_i,
  output logic [31:0]      m1_dat_o,
  output logic             m1_ack_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic [3:0]       s_sel_o,
  input  logic [31:0]      s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       gnt_o,
  output logic             hold_err_o
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          tie_m0;
  logic          hold;

  // last_q is the index of the master served most recently.
`ifdef NORFLASH16_ARB_PRIO_EN
  assign tie_m0 = 1'b1;
`else
  assign tie_m0 = last_q;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = tie_m0 ? G0 : G1;
        end else if (m0_cyc_i) begin
          state_d = G0;
        end else if (m1_cyc_i) begin
          state_d = G1;
        end
      end
      G0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? G1 : IDLE;
        end
      end
      G1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? G0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter runs only while the same grant persists; any change restarts it.
  always_comb begin
    hold  = (state_d == state_q) && (state_q != IDLE);
    cnt_d = '0;
    err_d = 1'b0;
    if (hold) begin
      if (cnt_q != CW'(HOLD_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
      err_d = (cnt_q == CW'(HOLD_MAX - 1));
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    s_adr_o  = '0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_sel_o  = 4'b0000;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    unique case (state_q)
      G0: begin
        s_adr_o  = m0_adr_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
      end
      G1: begin
        s_adr_o  = m1_adr_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
      end
      default: begin
      end
    endcase
  end

  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;
  assign gnt_o      = state_q;
  assign hold_err_o = err_q;

endmodule

// File: tb/tb_norflash16_arb.sv
// tb_norflash16_arb: randomized and directed bench for norflash16_arb.
// A transaction-level owner/last model predicts grants, routing and hold_err.
module tb_norflash16_arb;

  localparam int ADR_W = 32;
  localparam int HM    = 8;

  logic             sys_clk   = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic [ADR_W-1:0] m0_adr_i  = '0;
  logic             m0_cyc_i  = 1'b0;
  logic             m0_stb_i  = 1'b0;
  logic [3:0]       m0_sel_i  = '0;
  logic [31:0]      m0_dat_o;
  logic             m0_ack_o;
  logic [ADR_W-1:0] m1_adr_i  = '0;
  logic             m1_cyc_i  = 1'b0;
  logic             m1_stb_i  = 1'b0;
  logic [3:0]       m1_sel_i  = '0;
  logic [31:0]      m1_dat_o;
  logic             m1_ack_o;
  logic [ADR_W-1:0] s_adr_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic [3:0]       s_sel_o;
  logic [31:0]      s_dat_i   = '0;
  logic             s_ack_i   = 1'b0;
  logic [1:0]       gnt_o;
  logic             hold_err_o;

  int checks   = 0;
  int failures = 0;

  norflash16_arb #(.ADR_W(ADR_W), .HOLD_MAX(HM)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m0_adr_i(m0_adr_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o), .hold_err_o(hold_err_o)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: owner 0=none, 1=m0, 2=m1; last_m = master index last served.
  int owner  = 0;
  int last_m = 1;
  int hold_n = 0;

  function automatic int next_owner(int own, int lst, logic c0, logic c1);
    if (own == 1) return c0 ? 1 : (c1 ? 2 : 0);
    if (own == 2) return c1 ? 2 : (c0 ? 1 : 0);
    if (c0 && c1) return (lst == 1) ? 1 : 2;
    if (c0) return 1;
    if (c1) return 2;
    return 0;
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      owner  <= 0;
      last_m <= 1;
      hold_n <= 0;
    end else begin
      owner <= next_owner(owner, last_m, m0_cyc_i, m1_cyc_i);
      if (owner != 0 && next_owner(owner, last_m, m0_cyc_i, m1_cyc_i) != owner)
        last_m <= owner - 1;
      if (owner != 0 && next_owner(owner, last_m, m0_cyc_i, m1_cyc_i) == owner)
        hold_n <= hold_n + 1;
      else
        hold_n <= 0;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_adr_i = '0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_sel_i = '0;
    m1_adr_i = '0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_sel_i = '0;
    s_ack_i  = 1'b0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h1234; m0_sel_i = 4'hf;
    s_ack_i = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 ||
        s_adr_o !== '0 || s_sel_o !== 4'h0 || m0_ack_o !== 1'b0 ||
        m1_ack_o !== 1'b0 || hold_err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset: gnt=%b cyc=%b stb=%b adr=%h sel=%h ack0=%b ack1=%b err=%b, want all 0",
               gnt_o, s_cyc_o, s_stb_o, s_adr_o, s_sel_o, m0_ack_o, m1_ack_o, hold_err_o);
    end
    idle_inputs();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_single_m0();
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000fff0; m0_sel_i = 4'b1111;
    @(negedge sys_clk);
    checks++;
    if (gnt_o !== 2'b00) begin
      failures++;
      $display("FAIL single_latency: gnt=%b want 00", gnt_o);
    end
    tick();
    @(negedge sys_clk);
    checks++;
    if (gnt_o !== 2'b01 || s_adr_o !== 32'h0000fff0 || s_sel_o !== 4'hf ||
        s_cyc_o !== 1'b1 || s_stb_o !== 1'b1) begin
      failures++;
      $display("FAIL single_route: gnt=%b adr=%h sel=%h cyc=%b stb=%b want 01 0000fff0 f 1 1",
               gnt_o, s_adr_o, s_sel_o, s_cyc_o, s_stb_o);
    end
    s_ack_i = 1'b1; s_dat_i = 32'hcafe0001;
    #1;
    checks++;
    if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hcafe0001 || m1_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL single_ack: ack0=%b dat0=%h ack1=%b want 1 cafe0001 0",
               m0_ack_o, m0_dat_o, m1_ack_o);
    end
    tick();
    idle_inputs();
    tick();
    @(negedge sys_clk);
    checks++;
    if (gnt_o !== 2'b00) begin
      failures++;
      $display("FAIL single_release: gnt=%b want 00", gnt_o);
    end
  endtask

  task automatic test_tie_handoff();
    do_reset();
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_stb_i = 1'b1;
    tick();
    @(negedge sys_clk);
    checks++;
    if (gnt_o !== 2'b01) begin
      failures++;
      $display("FAIL tie_first: gnt=%b want 01", gnt_o);
    end
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    @(negedge sys_clk);
    checks++;
    if (gnt_o !== 2'b10) begin
      failures++;
      $display("FAIL tie_handoff: gnt=%b want 10 (no idle bubble)", gnt_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
      tick();
      @(negedge sys_clk);
      checks++;
      if (gnt_o !== exp_seq[i]) begin
        failures++;
        $display("FAIL rr_seq%0d: gnt=%b want %b", i, gnt_o, exp_seq[i]);
      end
      tick();
      m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_locked();
    do_reset();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h40; m1_sel_i = 4'hf;
    tick();
    @(negedge sys_clk);
    checks++;
    if (gnt_o !== 2'b10 || s_adr_o !== 32'h40) begin
      failures++;
      $display("FAIL lock_first: gnt=%b adr=%h want 10 40", gnt_o, s_adr_o);
    end
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h100;
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL lock_ack: ack1=%b ack0=%b want 1 0", m1_ack_o, m0_ack_o);
    end
    tick();
    s_ack_i = 1'b0; m1_adr_i = 32'h44;
    @(negedge sys_clk);
    checks++;
    if (gnt_o !== 2'b10 || s_adr_o !== 32'h44) begin
      failures++;
      $display("FAIL lock_second: gnt=%b adr=%h want 10 44", gnt_o, s_adr_o);
    end
    tick();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (gnt_o !== 2'b10) begin
      failures++;
      $display("FAIL lock_hold: gnt=%b want 10", gnt_o);
    end
    tick();
    @(negedge sys_clk);
    checks++;
    if (gnt_o !== 2'b01 || s_adr_o !== 32'h100) begin
      failures++;
      $display("FAIL lock_release: gnt=%b adr=%h want 01 100", gnt_o, s_adr_o);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_hold_err();
    int pulses;
    int at;
    pulses = 0;
    at = -1;
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    @(negedge sys_clk);
    if (hold_err_o === 1'b1) begin
      pulses++;
      at = 0;
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      @(negedge sys_clk);
      if (hold_err_o === 1'b1) begin
        pulses++;
        at = i;
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL hold_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (at != HM) begin
      failures++;
      $display("FAIL hold_time: pulse at cycle %0d want %0d", at, HM);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h80;
    tick();
    @(negedge sys_clk);
    checks++;
    if (gnt_o !== 2'b10) begin
      failures++;
      $display("FAIL areset_pre: gnt=%b want 10", gnt_o);
    end
    #2;
    sys_rst_n = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL areset_drop: gnt=%b cyc=%b stb=%b ack1=%b want 00 0 0 0",
               gnt_o, s_cyc_o, s_stb_o, m1_ack_o);
    end
    s_ack_i = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();
    @(negedge sys_clk);
    checks++;
    if (gnt_o !== 2'b01) begin
      failures++;
      $display("FAIL areset_tie: gnt=%b want 01", gnt_o);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [1:0]       e_gnt;
    logic [ADR_W-1:0] e_adr;
    logic             e_cyc;
    logic             e_stb;
    logic [3:0]       e_sel;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(0, 9) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = 1'($urandom_range(0, 1));
      m1_stb_i = 1'($urandom_range(0, 1));
      m0_adr_i = $urandom;
      m1_adr_i = $urandom;
      m0_sel_i = 4'($urandom_range(0, 15));
      m1_sel_i = 4'($urandom_range(0, 15));
      s_ack_i  = 1'($urandom_range(0, 1));
      s_dat_i  = $urandom;
      @(negedge sys_clk);
      e_gnt = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
      e_adr = (owner == 1) ? m0_adr_i : (owner == 2) ? m1_adr_i : '0;
      e_cyc = (owner == 1) ? m0_cyc_i : (owner == 2) ? m1_cyc_i : 1'b0;
      e_stb = (owner == 1) ? m0_stb_i : (owner == 2) ? m1_stb_i : 1'b0;
      e_sel = (owner == 1) ? m0_sel_i : (owner == 2) ? m1_sel_i : 4'h0;
      checks++;
      if (gnt_o !== e_gnt) begin
        failures++;
        $display("FAIL rnd_gnt[%0d]: got %b want %b", n, gnt_o, e_gnt);
      end
      checks++;
      if (s_adr_o !== e_adr || s_cyc_o !== e_cyc || s_stb_o !== e_stb || s_sel_o !== e_sel) begin
        failures++;
        $display("FAIL rnd_bus[%0d]: adr=%h cyc=%b stb=%b sel=%h want %h %b %b %h",
                 n, s_adr_o, s_cyc_o, s_stb_o, s_sel_o, e_adr, e_cyc, e_stb, e_sel);
      end
      checks++;
      if (m0_ack_o !== (s_ack_i && owner == 1) || m1_ack_o !== (s_ack_i && owner == 2) ||
          m0_dat_o !== s_dat_i || m1_dat_o !== s_dat_i) begin
        failures++;
        $display("FAIL rnd_ack[%0d]: ack0=%b ack1=%b dat0=%h dat1=%h want %b %b %h",
                 n, m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o,
                 s_ack_i && owner == 1, s_ack_i && owner == 2, s_dat_i);
      end
      checks++;
      if (hold_err_o !== (hold_n == HM)) begin
        failures++;
        $display("FAIL rnd_hold[%0d]: err=%b want %b (held %0d)",
                 n, hold_err_o, hold_n == HM, hold_n);
      end
      @(posedge sys_clk);
      #1;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_m0();
    test_tie_handoff();
    test_back_to_back();
    test_locked();
    test_hold_err();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
